// File: rtl/pipelined_multiplier.sv
// Two-stage pipelined integer multiplier with a valid strobe travelling alongside the data.
// Define MULT_SIGNED_EN to treat a/b as two's-complement (signed product, sign-extended result).
module pipelined_multiplier #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic                    valid_in,
  output logic [RESULT_WIDTH-1:0] out,
  output logic                    valid_out
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  localparam int unsigned ExtWidth  = (RESULT_WIDTH > ProdWidth) ? RESULT_WIDTH : ProdWidth;

  logic [DATA_WIDTH-1:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic                    v1_q;
  logic [RESULT_WIDTH-1:0] out_q, out_d;
  logic                    valid_out_q, valid_out_d;

  logic [ProdWidth-1:0]    a_ext;
  logic [ProdWidth-1:0]    prod;
  logic [ExtWidth-1:0]     prod_ext;

  // Operands only load on valid_in, so idle (possibly X) inputs never reach the datapath.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (valid_in) begin
      a_d = a;
      b_d = b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      v1_q <= valid_in;
    end
  end

  // Shift-and-add over DATA_WIDTH partial products; signed mode subtracts the MSB term.
  always_comb begin
`ifdef MULT_SIGNED_EN
    a_ext = {{DATA_WIDTH{a_q[DATA_WIDTH-1]}}, a_q};
`else
    a_ext = {{DATA_WIDTH{1'b0}}, a_q};
`endif
    prod = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (b_q[i]) begin
`ifdef MULT_SIGNED_EN
        if (i == DATA_WIDTH - 1) begin
          prod = prod - (a_ext << i);
        end else begin
          prod = prod + (a_ext << i);
        end
`else
        prod = prod + (a_ext << i);
`endif
      end
    end

`ifdef MULT_SIGNED_EN
    prod_ext = {ExtWidth{prod[ProdWidth-1]}};
`else
    prod_ext = '0;
`endif
    prod_ext[ProdWidth-1:0] = prod;
  end

  always_comb begin
    out_d       = out_q;
    valid_out_d = v1_q;
    if (v1_q) begin
      out_d = prod_ext[RESULT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      valid_out_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign out       = out_q;
  assign valid_out = valid_out_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed-vector bench for pipelined_multiplier (8-bit operands, 16-bit result).
module tb_pipelined_multiplier;

  localparam int unsigned DW = 8;
  localparam int unsigned RW = 16;
  localparam int unsigned NS = 140;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          valid_in;
  logic [RW-1:0] out;
  logic          valid_out;

  int checks;
  int failures;

  pipelined_multiplier #(
    .DATA_WIDTH  (DW),
    .RESULT_WIDTH(RW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .valid_in (valid_in),
    .out      (out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] ref_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
`ifdef MULT_SIGNED_EN
    logic signed [RW-1:0] sx;
    logic signed [RW-1:0] sy;
    sx = $signed(x);
    sy = $signed(y);
    ref_mul = sx * sy;
`else
    ref_mul = {8'h00, x} * {8'h00, y};
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'($urandom);
      a        = 8'($urandom);
      b        = 8'($urandom);
      tick();
      checks++;
      if (out !== 16'd0 || valid_out !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d out=%0h valid_out=%b expected out=0 valid_out=0",
                 i, out, valid_out);
      end
    end
    rst_n    = 1'b1;
    valid_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_release valid_out=%b expected 0", valid_out);
    end
    valid_in = 1'b1;
    a        = 8'd7;
    b        = 8'd9;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL first_latency_early valid_out=%b expected 0", valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || out !== 16'd63) begin
      failures++;
      $display("FAIL first_product out=%0d valid_out=%b expected out=63 valid_out=1",
               out, valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || out !== 16'd63) begin
      failures++;
      $display("FAIL first_product_after out=%0d valid_out=%b expected out=63 valid_out=0",
               out, valid_out);
    end
  endtask

  task automatic test_basic();
    valid_in = 1'b1;
    a        = 8'd3;
    b        = 8'd5;
    tick();
    valid_in = 1'b0;
    a        = 'x;
    b        = 'x;
    checks++;
    if (valid_out !== 1'b0 || out !== 16'd63) begin
      failures++;
      $display("FAIL basic_stage1 out=%0d valid_out=%b expected out=63 valid_out=0",
               out, valid_out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b1 || out !== 16'd15) begin
      failures++;
      $display("FAIL basic_result out=%0d valid_out=%b expected out=15 valid_out=1",
               out, valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_out !== 1'b0 || out !== 16'd15) begin
        failures++;
        $display("FAIL basic_hold cyc=%0d out=%0h valid_out=%b expected out=15 valid_out=0",
                 i, out, valid_out);
      end
    end
  endtask

  task automatic test_corners();
    logic [DW-1:0] ca [3];
    logic [DW-1:0] cb [3];
    logic [RW-1:0] ce [3];
    ca[0] = 8'hFF; cb[0] = 8'hFF;
    ca[1] = 8'h00; cb[1] = 8'd200;
    ca[2] = 8'h01; cb[2] = 8'h80;
`ifdef MULT_SIGNED_EN
    ca[1] = 8'h80; cb[1] = 8'h7F;
    ca[2] = 8'h80; cb[2] = 8'h80;
    ce[0] = 16'h0001;
    ce[1] = 16'hC080;
    ce[2] = 16'h4000;
`else
    ce[0] = 16'hFE01;
    ce[1] = 16'h0000;
    ce[2] = 16'h0080;
`endif
    for (int t = 0; t < 5; t++) begin
      if (t < 3) begin
        valid_in = 1'b1;
        a        = ca[t];
        b        = cb[t];
      end else begin
        valid_in = 1'b0;
        a        = 'x;
        b        = 'x;
      end
      tick();
      if (t >= 1 && t <= 3) begin
        checks++;
        if (valid_out !== 1'b1 || out !== ce[t-1]) begin
          failures++;
          $display("FAIL corner%0d out=%0h valid_out=%b expected out=%0h valid_out=1",
                   t - 1, out, valid_out, ce[t-1]);
        end
      end else if (t == 4) begin
        checks++;
        if (valid_out !== 1'b0 || out !== ce[2]) begin
          failures++;
          $display("FAIL corner_hold out=%0h valid_out=%b expected out=%0h valid_out=0",
                   out, valid_out, ce[2]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          sv [NS];
    logic [DW-1:0] sa [NS];
    logic [DW-1:0] sb [NS];
    logic [RW-1:0] exp_out;
    logic          exp_v;
    int            k;
    exp_out = '0;
    for (int i = 0; i < NS; i++) begin
      sv[i] = (i < 100) ? 1'b1 : 1'($urandom);
      sa[i] = 8'($urandom);
      sb[i] = 8'($urandom);
    end
    for (int t = 0; t < NS + 2; t++) begin
      if (t < NS) begin
        valid_in = sv[t];
        a        = sa[t];
        b        = sb[t];
      end else begin
        valid_in = 1'b0;
      end
      tick();
      if (t >= 1) begin
        k     = t - 1;
        exp_v = (k < NS) ? sv[k] : 1'b0;
        if (exp_v) exp_out = ref_mul(sa[k], sb[k]);
        checks++;
        if (valid_out !== exp_v || out !== exp_out) begin
          failures++;
          $display("FAIL stream idx=%0d out=%0h valid_out=%b expected out=%0h valid_out=%b",
                   k, out, valid_out, exp_out, exp_v);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    valid_in = 1'b1;
    a        = 8'd10;
    b        = 8'd10;
    tick();
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if (out !== 16'd0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async out=%0h valid_out=%b expected out=0 valid_out=0",
               out, valid_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 16'd0 || valid_out !== 1'b0) begin
        failures++;
        $display("FAIL midreset_after cyc=%0d out=%0h valid_out=%b expected out=0 valid_out=0",
                 i, out, valid_out);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
